// File: rtl/npc_delay_pkg.sv
// -----------------------------------------------------------------------------
// npc_delay_pkg
// Shared definitions for the memory delay arbiter slice:
//   state_t    - arbiter/sequencer FSM encoding (IDLE, WAIT, RESP)
//   LFSR_TAPS  - Galois tap mask for x^8+x^6+x^5+x^4+1
//   lfsr_next  - one step of the right-shifting Galois LFSR
// -----------------------------------------------------------------------------
package npc_delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Right-shifting Galois form: the bit falling out of position 0 is fed
  // back into every tap position at once.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    lfsr_next = {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/mem_delay_arb_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Galois LFSR used as the pseudo-random delay source.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, loads SEED
//   lfsr  - current LFSR value
// Parameters:
//   SEED  - reset value, must be nonzero (an all-zero register never moves)
// -----------------------------------------------------------------------------
module lfsr8
  import npc_delay_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  // Advances every cycle regardless of what the arbiter is doing, so the
  // delay picked depends on when a request happens to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/mem_delay_arb.sv
// -----------------------------------------------------------------------------
// mem_delay_arb
// Two-requester round-robin arbiter plus latency sequencer modelling a shared
// memory port. One transaction is outstanding at a time; its response is
// released a programmable (or pseudo-random) number of cycles after accept.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   req0_valid/req0_ready  - requester 0 (IFU) handshake
//   req1_valid/req1_ready  - requester 1 (LSU) handshake
//   cfg_delay              - fixed delay, sampled only at accept (RANDOM=0)
//   resp_valid/resp_ready  - response handshake
//   resp_id                - requester that owns the response
//   busy                   - high whenever the FSM is not IDLE
// Parameters:
//   DELAY_W - delay width (1..8)
//   RANDOM  - 0: delay from cfg_delay, 1: delay from low LFSR bits
//   SEED    - LFSR reset value (nonzero)
// -----------------------------------------------------------------------------
module mem_delay_arb
  import npc_delay_pkg::*;
#(
  parameter int         DELAY_W = 4,
  parameter int         RANDOM  = 0,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic               busy
);

  state_t             state;
  state_t             state_nxt;
  logic [DELAY_W-1:0] cnt;
  logic [DELAY_W-1:0] cnt_nxt;
  logic               last;
  logic               last_nxt;
  logic               id_nxt;
  logic               winner;
  logic               accept;
  logic [DELAY_W-1:0] d_sel;
  logic [7:0]         lfsr;
  logic               unused_lfsr;

  lfsr8 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Upper LFSR bits only matter when DELAY_W is 8; fold them so the
  // remaining bits are visibly consumed.
  assign unused_lfsr = ^lfsr;

  // With both requesters valid the one that did not win last time goes
  // next; a lone valid requester always wins.
  assign winner = (req0_valid && req1_valid) ? ~last : req1_valid;

  assign d_sel = (RANDOM != 0) ? lfsr[DELAY_W-1:0] : cfg_delay;

  // Response side is purely state-decoded, so resp_ready never reaches an
  // output combinationally.
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    id_nxt     = resp_id;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !winner;
          req1_ready = req1_valid && winner;
        end
        accept = req0_ready || req1_ready;
        if (accept) begin
          id_nxt   = winner;
          last_nxt = winner;
          if (d_sel == '0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = d_sel;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - DELAY_W'(1);
        if (cnt == DELAY_W'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset drops any in-flight transaction and sets last=1 so requester 0
  // wins the first contested arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      resp_id <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      resp_id <= id_nxt;
    end
  end

endmodule

// File: doc/mem_delay_arb.md
# mem_delay_arb

Two-requester arbiter and latency sequencer that models a shared memory port with a programmable or pseudo-random response delay. It sits between the NPC fetch and load/store units and the simulated memory, granting one outstanding transaction at a time and releasing the response after the selected number of cycles. It is used to stress pipeline handshakes under variable memory latency.

## Interface
- `DELAY_W`, default 4: width of the delay value; legal range 1..8.
- `RANDOM`, default 0: delay source. 0 selects `cfg_delay`; 1 selects the low `DELAY_W` bits of the internal LFSR.
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req0_valid`, input, 1: request from requester 0 (IFU).
- `req0_ready`, output, 1: request accepted from requester 0.
- `req1_valid`, input, 1: request from requester 1 (LSU).
- `req1_ready`, output, 1: request accepted from requester 1.
- `cfg_delay`, input, `DELAY_W`: fixed delay used when `RANDOM`=0.
- `resp_valid`, output, 1: response available.
- `resp_ready`, input, 1: consumer accepts the response.
- `resp_id`, output, 1: index of the requester that owns the response.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states:
  - IDLE: `reqX_ready` is asserted combinationally for the arbitration winner only.
  - WAIT: counting down the delay.
  - RESP: `resp_valid` is 1.
- Arbitration is round-robin via the `last` register:
  - If both requesters are valid, the one not equal to `last` wins.
  - If only one is valid, it wins.
- Accept happens on an edge in IDLE where winner valid and ready are both high. At accept:
  - latch `resp_id` to the winner;
  - latch `d` = `cfg_delay` or `lfsr[DELAY_W-1:0]`;
  - set `last` to the winner.
- If `d`=0, go to RESP. Otherwise go to WAIT with `cnt`=`d`.
- WAIT:
  - `cnt` decrements by 1 every cycle.
  - When `cnt`==1, go to RESP on that edge.
  - No ready is asserted while in WAIT.
- RESP:
  - `resp_valid`=1 and `resp_id` is held stable.
  - On `resp_valid` and `resp_ready`, go to IDLE.
  - No accept occurs in the same cycle as the response handshake.
- `cfg_delay` is sampled only at accept. Changes during WAIT or RESP have no effect.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle regardless of state, and the value present in the accept cycle is used.
- Reset behaviour (applies at any time):
  - State returns to IDLE.
  - `resp_valid`=0, `resp_id`=0, `busy`=0.
  - `cnt`=0, `last`=1, so requester 0 wins first.
  - `lfsr`=`SEED`.
  - Both `reqX_ready` outputs are forced to 0 while `rst` is high.
  - A transaction in flight is dropped with no response.

## Timing
- Accept at edge T: `resp_valid` is first high in cycle T+1+`d`.
  - `d`=0 gives 1 cycle.
  - `d`=`2^DELAY_W`-1 gives the maximum.
- Throughput: at most one transaction every `d`+2 cycles when `resp_ready` is held at 1.
- Outputs:
  - `resp_valid`, `resp_id` and `busy` are registered (state-decoded only).
  - `reqX_ready` is combinational from `reqX_valid`, state, `last` and `rst`.
- No combinational path exists from `resp_ready` to any output.
- Backpressure: RESP holds indefinitely until `resp_ready` is high.

## Structure
- Shared package `npc_delay_pkg` holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the LFSR tap mask constant 8'hB8.
- Sub-module `lfsr8`: 8-bit Galois LFSR with `clk`, `rst`, parameter `SEED` and 8-bit output. It is instantiated once.
- Arbiter, counter and FSM live in the top module.

## Test plan
- Fixed delay:
  - Stimulus: `RANDOM`=0, `cfg_delay`=3, `req0_valid` pulsed and accepted at edge T, `resp_ready`=1.
  - Response: `resp_valid` high only in cycle T+4, `resp_id`=0, `busy` high for cycles T+1..T+4.
- Zero delay and backpressure:
  - Stimulus: `cfg_delay`=0, `req1` accepted at edge T, `resp_ready`=0 for 5 cycles then 1.
  - Response: `resp_valid` high from T+1 and held with `resp_id`=1 until the handshake, then IDLE.
- Round-robin:
  - Stimulus: both valid continuously, `cfg_delay`=1, `resp_ready`=1.
  - Response: grants alternate 0,1,0,1 and exactly one ready is high per accept.
- Config change mid-flight:
  - Stimulus: `cfg_delay`=7 at accept, changed to 1 during WAIT.
  - Response: response still at T+8.
- Random mode:
  - Stimulus: `RANDOM`=1, `SEED`=8'hA5, 20 back-to-back requests.
  - Response: each delay equals the low `DELAY_W` bits of the LFSR sequence sampled in its accept cycle, checked against a reference model.
- Reset mid-operation:
  - Stimulus: `rst` asserted during WAIT with `cnt`=2.
  - Response: next cycle IDLE, `resp_valid`=0, no response ever issued, and the next accept goes to requester 0.
